ysyx_25050147_load_unit: RTL and testbench

Load-side counterpart of the store formatter: accepts a load request from EXU (funct3 op plus byte address), checks alignment, issues a word-aligned read on the data-memory read channel, waits for the response with a watchdog, then extracts and sign- or zero-extends the addressed byte, half or word. The registered result goes to WBU over a valid/ready handshake. It sits between EXU/LSU control and the data-memory read port, with one load outstanding at a time.

---
 rtl/ysyx_25050147_lsu_pkg.sv | 41 ++++
 rtl/ysyx_25050147_load_align.sv | 41 ++++
 rtl/ysyx_25050147_load_unit.sv | 132 +++++++++++++
 tb/tb_ysyx_25050147_load_unit.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25050147_lsu_pkg.sv
// Shared LSU definitions: load funct3 codes, response
// error codes, FSM state codes, latched request bundle.
package ysyx_25050147_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_AR     = 2'd1;
  localparam logic [1:0] ST_R_WAIT = 2'd2;
  localparam logic [1:0] ST_RSP    = 2'd3;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] off;
  } ld_req_t;

  function automatic logic load_legal(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (op)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~off[0];
      F3_LW:         ok = (off == 2'd0);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_25050147_load_align.sv
// Combinational load extractor: picks byte/half/word
// from a little-endian word and sign/zero extends it.
// Ports: rdata, offset, op in; data out.
module ysyx_25050147_load_align
  import ysyx_25050147_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (offset)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = offset[1] ? rdata[31:16]
                  : rdata[15:0];
  end

  always_comb begin
    data = '0;
    case (op)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, b};
      F3_LHU:  data = {16'd0, h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25050147_load_unit.sv
// Load unit: one outstanding load, AR/R read channel,
// watchdog, extraction and registered WBU response.
// Ports: req_* from EXU, mem_* read port, rsp_* to WBU.
module ysyx_25050147_load_unit
  import ysyx_25050147_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(TIMEOUT);

  logic [1:0]      state_q, state_d;
  ld_req_t         req_q, req_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [31:0]     data_q, data_d;
  logic [1:0]      err_q, err_d;
  logic [31:0]     ext_data;

  ysyx_25050147_load_align u_align (
    .rdata  (mem_rdata),
    .offset (req_q.off),
    .op     (req_q.op),
    .data   (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    araddr_d = araddr_q;
    wd_d     = wd_q;
    data_d   = data_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.op  = req_op;
          req_d.off = req_addr[1:0];
          if (load_legal(req_op,
                         req_addr[1:0])) begin
            araddr_d = {req_addr[31:2], 2'b00};
            state_d  = ST_AR;
          end else begin
            data_d  = '0;
            err_d   = ERR_ALIGN;
            state_d = ST_RSP;
          end
        end
      end
      ST_AR: begin
        if (mem_arready) begin
          wd_d    = '0;
          state_d = ST_R_WAIT;
        end
      end
      ST_R_WAIT: begin
        if (mem_rvalid) begin
          if (mem_rresp != 2'b00) begin
            data_d = '0;
            err_d  = ERR_BUS;
          end else begin
            data_d = ext_data;
            err_d  = ERR_OK;
          end
          state_d = ST_RSP;
        end else if (wd_q == WD_MAX) begin
          // slave presumed dead; late data
          // is never drained
          data_d  = '0;
          err_d   = ERR_TMO;
          state_d = ST_RSP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      araddr_q <= '0;
      wd_q     <= '0;
      data_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      araddr_q <= araddr_d;
      wd_q     <= wd_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign req_ready   = rst_n &&
                       (state_q == ST_IDLE);
  assign mem_arvalid = (state_q == ST_AR);
  assign mem_rready  = (state_q == ST_R_WAIT);
  assign rsp_valid   = (state_q == ST_RSP);
  assign mem_araddr  = araddr_q;
  assign rsp_data    = data_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_ysyx_25050147_load_unit.sv
// Scoreboard bench for the load unit: random loads,
// memory responder, reference model, response monitor.
module tb_ysyx_25050147_load_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  ysyx_25050147_load_unit #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_araddr  (mem_araddr),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    bit          tmo;
    bit          rst;
    int          ard;
    int          rd;
  } mem_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  mem_t mq[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_legal = 0;
  int n_rdata = 0;
  int arv_rise = 0;
  int ar_hs = 0;
  int r_hs = 0;
  int ready_low = 0;
  bit rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model from the load rules
  function automatic bit ref_legal(
    input logic [2:0] op, input logic [31:0] a
  );
    int sz;
    case (op)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    return 1'b0;
    endcase
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_ext(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] rdata
  );
    int unsigned w;
    int v;
    w = rdata >> (8 * (a % 4));
    case (op)
      3'd0: begin
        v = int'(w % 256);
        if (v > 127) v = v - 256;
        return 32'(v);
      end
      3'd1: begin
        v = int'(w % 65536);
        if (v > 32767) v = v - 65536;
        return 32'(v);
      end
      3'd4: return 32'(w % 256);
      3'd5: return 32'(w % 65536);
      default: return rdata;
    endcase
  endfunction

  task automatic issue(
    input logic [2:0] op, input logic [31:0] addr,
    input logic [31:0] rdata, input logic [1:0] rresp,
    input bit tmo, input bit rst,
    input int ard, input int rd
  );
    int n;
    bit lg;
    mem_t m;
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL req_wait got no ready want ready");
        req_valid = 1'b0;
        return;
      end
    end
    lg = ref_legal(op, addr);
    if (lg) begin
      m.addr = addr; m.rdata = rdata;
      m.rresp = rresp; m.tmo = tmo; m.rst = rst;
      m.ard = ard; m.rd = rd;
      mq.push_back(m);
      n_legal++;
      if (!tmo && !rst) n_rdata++;
    end
    if (!(lg && rst)) begin
      if (!lg) begin
        e.data = 32'd0; e.err = 2'b01;
        e.lat = cyc + 1;
      end else if (tmo) begin
        e.data = 32'd0; e.err = 2'b11; e.lat = -1;
      end else begin
        e.err = (rresp != 2'b00) ? 2'b10 : 2'b00;
        e.data = (rresp != 2'b00) ? 32'd0
                 : ref_ext(op, addr, rdata);
        e.lat = (ard == 0 && rd == 0) ? cyc + 3 : -1;
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_addr = $urandom;
  endtask

  task automatic serve(input mem_t m);
    int n;
    bit hs;
    if (m.ard > 0)
      repeat (m.ard) begin @(posedge clk); #1; end
    mem_arready = 1'b1;
    n = 0; hs = 0;
    while (n < 50) begin
      @(negedge clk);
      if (mem_arvalid && mem_arready) begin
        hs = 1; break;
      end
      n++;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL ar_wait got none want handshake");
      @(posedge clk); #1;
      mem_arready = 1'b0;
      return;
    end
    if (mem_araddr !== {m.addr[31:2], 2'b00}) begin
      errors++;
      $display("FAIL araddr got %h want %h",
               mem_araddr, {m.addr[31:2], 2'b00});
    end
    @(posedge clk); #1;
    mem_arready = 1'b0;
    if (m.rst) return;
    if (m.tmo) begin
      n = 0;
      while (n < 30) begin
        @(negedge clk);
        n++;
        if (rsp_valid) break;
      end
      checks++;
      if (n - 1 != TMO + 1) begin
        errors++;
        $display("FAIL tmo_lat got %0d want %0d",
                 n - 1, TMO + 1);
      end
      return;
    end
    if (m.rd > 0)
      repeat (m.rd) begin @(posedge clk); #1; end
    mem_rvalid = 1'b1;
    mem_rdata = m.rdata;
    mem_rresp = m.rresp;
    n = 0; hs = 0;
    while (n < 50) begin
      @(negedge clk);
      if (mem_rvalid && mem_rready) begin
        hs = 1; break;
      end
      n++;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL r_wait got none want handshake");
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    mem_rresp = 2'b00;
  endtask

  // memory responder
  initial begin
    mem_arready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    mem_rresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (mq.size() != 0) serve(mq.pop_front());
    end
  end

  // WBU ready driver
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_low > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) ready_low--;
      end else if (rand_ready) begin
        rsp_ready = 1'($urandom % 2);
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  // response and channel monitor
  bit          in_rsp = 0;
  logic [31:0] cap_data;
  logic [1:0]  cap_err;
  bit          arv_prev = 0;
  bit          arr_prev = 0;
  logic [31:0] ara_prev;
  exp_t        ce;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1;
          cap_data = rsp_data;
          cap_err = rsp_err;
          checks++;
          if (req_ready) begin
            errors++;
            $display("FAIL req_ready_in_rsp got 1 want 0");
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp got %h/%0d want none",
                     rsp_data, rsp_err);
          end else begin
            ce = sb.pop_front();
            if (rsp_data !== ce.data ||
                rsp_err !== ce.err) begin
              errors++;
              $display("FAIL rsp got %h/%0d want %h/%0d",
                       rsp_data, rsp_err, ce.data, ce.err);
            end
            if (ce.lat >= 0) begin
              checks++;
              if (cyc != ce.lat) begin
                errors++;
                $display("FAIL rsp_lat got %0d want %0d",
                         cyc, ce.lat);
              end
            end
          end
        end else begin
          checks++;
          if (rsp_data !== cap_data ||
              rsp_err !== cap_err) begin
            errors++;
            $display("FAIL rsp_hold got %h/%0d want %h/%0d",
                     rsp_data, rsp_err, cap_data, cap_err);
          end
        end
        if (rsp_ready) in_rsp = 0;
      end
      if (mem_arvalid && !arv_prev) arv_rise++;
      if (arv_prev && !arr_prev) begin
        checks++;
        if (!mem_arvalid || mem_araddr !== ara_prev) begin
          errors++;
          $display("FAIL ar_hold got %b/%h want 1/%h",
                   mem_arvalid, mem_araddr, ara_prev);
        end
      end
      if (mem_arvalid && mem_arready) ar_hs++;
      if (mem_rvalid && mem_rready) r_hs++;
      arv_prev = mem_arvalid;
      arr_prev = mem_arready;
      ara_prev = mem_araddr;
    end else begin
      in_rsp = 0;
      arv_prev = 0;
      arr_prev = 0;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain got %0d pending want 0",
               sb.size());
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 ||
        rsp_err !== 2'd0 || mem_arvalid !== 1'b0 ||
        mem_rready !== 1'b0 || mem_araddr !== 32'd0 ||
        req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s got %b%b%b%b %h %h %0d want zeros",
               nm, rsp_valid, mem_arvalid, mem_rready,
               req_ready, mem_araddr, rsp_data, rsp_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic [2:0] op;
    logic [31:0] a;
    int k;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(3'b000, 32'h8000_0003, 32'h80FF_1234,
          2'b00, 0, 0, 0, 0);
    issue(3'b101, 32'h8000_0002, 32'hBEEF_0000,
          2'b00, 0, 0, 0, 0);
    issue(3'b001, 32'h8000_0000, 32'h0000_8001,
          2'b00, 0, 0, 0, 0);
    issue(3'b010, 32'h8000_0001, 32'h1111_2222,
          2'b00, 0, 0, 0, 0);
    issue(3'b001, 32'h8000_0003, 32'h1111_2222,
          2'b00, 0, 0, 0, 0);
    issue(3'b011, 32'h8000_0000, 32'h1111_2222,
          2'b00, 0, 0, 0, 0);
    drain();
    ready_low = 4;
    issue(3'b010, 32'h1234_5678, 32'hCAFE_F00D,
          2'b00, 0, 0, 3, 1);
    drain();
    issue(3'b100, 32'h0000_0101, 32'h1234_5678,
          2'b10, 0, 0, 0, 0);
    issue(3'b010, 32'h0000_0200, 32'h1234_5678,
          2'b00, 1, 0, 0, 0);
    drain();

    issue(3'b100, 32'h0000_0040, 32'hAAAA_AAAA,
          2'b00, 0, 1, 0, 0);
    n = 0;
    while (!mem_rready && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL req_ready_rst got %b want 0", req_ready);
    end
    @(negedge clk);
    check_zero("reset_rwait");
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(3'b100, 32'h0000_0042, 32'h00C3_0000,
          2'b00, 0, 0, 1, 0);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      k = int'($urandom % 10);
      issue(op, a, $urandom,
            (k == 1) ? 2'($urandom_range(1, 3)) : 2'b00,
            k == 0, 0,
            int'($urandom % 4), int'($urandom % 4));
      repeat ($urandom % 3) @(posedge clk);
    end
    drain();

    checks++;
    if (arv_rise != n_legal) begin
      errors++;
      $display("FAIL arvalid_count got %0d want %0d",
               arv_rise, n_legal);
    end
    checks++;
    if (ar_hs != n_legal) begin
      errors++;
      $display("FAIL ar_hs_count got %0d want %0d",
               ar_hs, n_legal);
    end
    checks++;
    if (r_hs != n_rdata) begin
      errors++;
      $display("FAIL r_hs_count got %0d want %0d",
               r_hs, n_rdata);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
